// File: rtl/axi_s_inline_inserter_pkg.sv
// Shared definitions for the AXI-Stream inline inserter.
// Holds the FSM state encoding and the beat width constants used by the
// top level and by the registered output stage.
package axi_s_inline_inserter_pkg;

  localparam int unsigned AXIS_DATA_W = 64;  // default tdata width
  localparam int unsigned AXIS_BYTE_W = 8;   // bits covered by one tkeep bit
  localparam int unsigned CNT_W_DEF   = 32;  // default packet counter width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_INJ  = 2'd2
  } state_t;

endpackage

// File: rtl/axi_s_inline_inserter_out.sv
// One-deep registered AXI-Stream output stage.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   in_valid/in_*  beat offered by the arbiter (only meaningful when load_ok_c)
//   out_*          registered master-side stream
//   out_ready      downstream tready
//   load_ok_c      register may take a new beat this cycle
module axi_s_out_reg
  import axi_s_inline_inserter_pkg::*;
#(
  parameter  int unsigned DATA_W = AXIS_DATA_W,
  localparam int unsigned KEEP_W = DATA_W / AXIS_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [KEEP_W-1:0] in_keep,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [KEEP_W-1:0] out_keep,
  input  logic              out_ready,
  output logic              load_ok_c
);

  assign load_ok_c = !out_valid || out_ready;

  // Payload only changes on a real load, so it stays put while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_keep  <= '0;
    end else if (load_ok_c) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
        out_keep <= in_keep;
      end
    end
  end

endmodule

// File: rtl/axi_s_inline_inserter.sv
// AXI-Stream packet inserter: merges whole packets from an inject port into
// the main packet stream, switching source only on packet boundaries.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   insert_en                allow the inject port to be granted
//   s_packet_axis_*          main stream slave port
//   s_inject_axis_*          inject stream slave port
//   m_packet_axis_*          merged stream master port (registered)
//   pass_cnt, inj_cnt        saturating counts of forwarded main/inject packets
module axi_s_inline_inserter
  import axi_s_inline_inserter_pkg::*;
#(
  parameter  int unsigned DATA_W   = AXIS_DATA_W,
  parameter  int unsigned CNT_W    = CNT_W_DEF,
  parameter  bit          INJ_PRIO = 1'b1,
  localparam int unsigned KEEP_W   = DATA_W / AXIS_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              insert_en,
  input  logic [DATA_W-1:0] s_packet_axis_tdata,
  input  logic              s_packet_axis_tvalid,
  input  logic              s_packet_axis_tlast,
  input  logic [KEEP_W-1:0] s_packet_axis_tkeep,
  output logic              s_packet_axis_tready,
  input  logic [DATA_W-1:0] s_inject_axis_tdata,
  input  logic              s_inject_axis_tvalid,
  input  logic              s_inject_axis_tlast,
  input  logic [KEEP_W-1:0] s_inject_axis_tkeep,
  output logic              s_inject_axis_tready,
  output logic [DATA_W-1:0] m_packet_axis_tdata,
  output logic              m_packet_axis_tvalid,
  output logic              m_packet_axis_tlast,
  output logic [KEEP_W-1:0] m_packet_axis_tkeep,
  input  logic              m_packet_axis_tready,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  inj_cnt
);

  state_t              state_q, state_d;
  logic                load_ok_c;
  logic                pkt_tready_c, inj_tready_c;
  logic                beat_valid_c, beat_last_c;
  logic [DATA_W-1:0]   beat_data_c;
  logic [KEEP_W-1:0]   beat_keep_c;
  logic                pass_done_c, inj_done_c;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Arbitration, grant-gated tready and source mux. IDLE grants nothing so
  // every arbitration costs one dead cycle; tready is forced low in reset.
  always_comb begin
    state_d      = state_q;
    pkt_tready_c = 1'b0;
    inj_tready_c = 1'b0;
    beat_valid_c = 1'b0;
    beat_data_c  = s_packet_axis_tdata;
    beat_last_c  = s_packet_axis_tlast;
    beat_keep_c  = s_packet_axis_tkeep;
    pass_done_c  = 1'b0;
    inj_done_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_inject_axis_tvalid && insert_en && (INJ_PRIO || !s_packet_axis_tvalid))
          state_d = ST_INJ;
        else if (s_packet_axis_tvalid)
          state_d = ST_PASS;
      end
      ST_PASS: begin
        pkt_tready_c = rst && load_ok_c;
        beat_valid_c = s_packet_axis_tvalid && pkt_tready_c;
        if (beat_valid_c && s_packet_axis_tlast) begin
          pass_done_c = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_INJ: begin
        inj_tready_c = rst && load_ok_c;
        beat_valid_c = s_inject_axis_tvalid && inj_tready_c;
        beat_data_c  = s_inject_axis_tdata;
        beat_last_c  = s_inject_axis_tlast;
        beat_keep_c  = s_inject_axis_tkeep;
        if (beat_valid_c && s_inject_axis_tlast) begin
          inj_done_c = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_packet_axis_tready = pkt_tready_c;
  assign s_inject_axis_tready = inj_tready_c;

  // Saturating packet counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pass_cnt <= '0;
      inj_cnt  <= '0;
    end else begin
      if (pass_done_c && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
      if (inj_done_c  && (inj_cnt  != '1)) inj_cnt  <= inj_cnt  + CNT_W'(1);
    end
  end

  axi_s_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (beat_valid_c),
    .in_data   (beat_data_c),
    .in_last   (beat_last_c),
    .in_keep   (beat_keep_c),
    .out_valid (m_packet_axis_tvalid),
    .out_data  (m_packet_axis_tdata),
    .out_last  (m_packet_axis_tlast),
    .out_keep  (m_packet_axis_tkeep),
    .out_ready (m_packet_axis_tready),
    .load_ok_c (load_ok_c)
  );

endmodule

// File: tb/tb_axi_s_inline_inserter.sv
// Self-checking bench for axi_s_inline_inserter (4-bit counters so that
// saturation is reached inside the random-backpressure run).
module tb_axi_s_inline_inserter;
  import axi_s_inline_inserter_pkg::*;

  localparam int unsigned DW  = 64;
  localparam int unsigned KW  = 8;
  localparam int unsigned CW  = 4;
  localparam int          TMO = 500;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [KW-1:0] keep;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          insert_en = 1'b1;
  logic [DW-1:0] pkt_data = '0;
  logic          pkt_valid = 1'b0, pkt_last = 1'b0;
  logic [KW-1:0] pkt_keep = '0;
  logic          pkt_tready;
  logic [DW-1:0] inj_data = '0;
  logic          inj_valid = 1'b0, inj_last = 1'b0;
  logic [KW-1:0] inj_keep = '0;
  logic          inj_tready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic [KW-1:0] m_keep;
  logic          m_ready = 1'b1;
  logic [CW-1:0] pass_cnt, inj_cnt;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  beat_t exp_q[$];
  int    out_src_q[$];
  int    out_cyc_q[$];
  bit    mon_en = 1'b1;
  bit    rnd_ready = 1'b0;
  bit    chk_inj_rdy = 1'b0;
  bit    inj_rdy_seen = 1'b0;
  bit    prev_stall = 1'b0;
  bit    in_pkt = 1'b0;
  int    cur_src = 0;
  beat_t prev_b, mon_e;
  int    k;

  axi_s_inline_inserter #(
    .DATA_W   (DW),
    .CNT_W    (CW),
    .INJ_PRIO (1'b1)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .insert_en            (insert_en),
    .s_packet_axis_tdata  (pkt_data),
    .s_packet_axis_tvalid (pkt_valid),
    .s_packet_axis_tlast  (pkt_last),
    .s_packet_axis_tkeep  (pkt_keep),
    .s_packet_axis_tready (pkt_tready),
    .s_inject_axis_tdata  (inj_data),
    .s_inject_axis_tvalid (inj_valid),
    .s_inject_axis_tlast  (inj_last),
    .s_inject_axis_tkeep  (inj_keep),
    .s_inject_axis_tready (inj_tready),
    .m_packet_axis_tdata  (m_data),
    .m_packet_axis_tvalid (m_valid),
    .m_packet_axis_tlast  (m_last),
    .m_packet_axis_tkeep  (m_keep),
    .m_packet_axis_tready (m_ready),
    .pass_cnt             (pass_cnt),
    .inj_cnt              (inj_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      m_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // data = {src, packet id, beat index}; beat 1 carries a zero tkeep.
  function automatic beat_t mk_beat(input int src, input int pkt, input int idx, input int len);
    beat_t b;
    b.data = {8'(src), 24'(pkt), 32'(idx)};
    b.last = (idx == len - 1);
    b.keep = (idx == 1) ? 8'h00 : 8'(8'hFF >> idx);
    return b;
  endfunction

  // Entered and left at posedge+1; accepted beats join the expected queue.
  task automatic send_pkt(input int src, input int pkt, input int len, input int gap);
    beat_t b;
    bit    hs;
    int    w;
    repeat (gap) begin @(posedge clk); #1; end
    for (int i = 0; i < len; i++) begin
      b = mk_beat(src, pkt, i, len);
      if (src == 0) begin
        pkt_valid = 1'b1; pkt_data = b.data; pkt_last = b.last; pkt_keep = b.keep;
      end else begin
        inj_valid = 1'b1; inj_data = b.data; inj_last = b.last; inj_keep = b.keep;
      end
      hs = 1'b0;
      w  = 0;
      while (!hs && w < TMO) begin
        @(negedge clk);
        hs = (src == 0) ? pkt_tready : inj_tready;
        if (hs) exp_q.push_back(b);
        @(posedge clk); #1;
        w++;
      end
      if (!hs) begin
        check_eq("src_timeout", 64'(hs), 64'd1);
        break;
      end
    end
    if (src == 0) begin pkt_valid = 1'b0; pkt_last = 1'b0; end
    else          begin inj_valid = 1'b0; inj_last = 1'b0; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Output monitor: order/data scoreboard, hold-while-stalled, no interleave.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check_eq("hold_valid", 64'(m_valid), 64'd1);
        check_eq("hold_data",  m_data, prev_b.data);
        check_eq("hold_last",  64'(m_last), 64'(prev_b.last));
        check_eq("hold_keep",  64'(m_keep), 64'(prev_b.keep));
      end
      if (m_valid && m_ready) begin
        check_eq("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("out_data", m_data, mon_e.data);
          check_eq("out_last", 64'(m_last), 64'(mon_e.last));
          check_eq("out_keep", 64'(m_keep), 64'(mon_e.keep));
        end
        if (in_pkt) check_eq("no_interleave", 64'(m_data[63:56]), 64'(cur_src));
        cur_src = int'(m_data[63:56]);
        in_pkt  = !m_last;
        out_src_q.push_back(cur_src);
        out_cyc_q.push_back(cyc);
      end
      prev_stall = m_valid && !m_ready;
      prev_b     = '{data: m_data, last: m_last, keep: m_keep};
    end else begin
      prev_stall = 1'b0;
      in_pkt     = 1'b0;
    end
    if (chk_inj_rdy && inj_tready) inj_rdy_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_m_valid",    64'(m_valid), 64'd0);
    check_eq("rst_m_data",     m_data, 64'd0);
    check_eq("rst_pass_cnt",   64'(pass_cnt), 64'd0);
    check_eq("rst_inj_cnt",    64'(inj_cnt), 64'd0);
    check_eq("rst_pkt_tready", 64'(pkt_tready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // 1: main only, 3 beats, latency from valid to first output beat = 2 cycles
    out_src_q.delete(); out_cyc_q.delete();
    k = cyc;
    send_pkt(0, 1, 3, 0);
    drain();
    check_eq("t1_nbeats", 64'(out_cyc_q.size()), 64'd3);
    if (out_cyc_q.size() == 3) begin
      check_eq("t1_cyc0", 64'(out_cyc_q[0]), 64'(k + 2));
      check_eq("t1_cyc2", 64'(out_cyc_q[2]), 64'(k + 4));
    end
    check_eq("t1_pass_cnt", 64'(pass_cnt), 64'd1);

    // 2: both valid in IDLE, inject wins and goes out whole first
    out_src_q.delete();
    fork
      send_pkt(1, 2, 2, 0);
      send_pkt(0, 3, 3, 0);
    join
    drain();
    check_eq("t2_nbeats", 64'(out_src_q.size()), 64'd5);
    if (out_src_q.size() == 5) begin
      check_eq("t2_src0", 64'(out_src_q[0]), 64'd1);
      check_eq("t2_src1", 64'(out_src_q[1]), 64'd1);
      check_eq("t2_src2", 64'(out_src_q[2]), 64'd0);
    end
    check_eq("t2_inj_cnt",  64'(inj_cnt), 64'd1);
    check_eq("t2_pass_cnt", 64'(pass_cnt), 64'd2);

    // 3: insert_en=0 keeps the inject port locked out
    insert_en = 1'b0;
    inj_valid = 1'b1; inj_last = 1'b1; inj_data = 64'hBAD0_0000_0000_0001; inj_keep = 8'hFF;
    inj_rdy_seen = 1'b0; chk_inj_rdy = 1'b1;
    send_pkt(0, 4, 2, 2);
    repeat (10) begin @(posedge clk); #1; end
    drain();
    chk_inj_rdy = 1'b0;
    check_eq("t3_inj_tready", 64'(inj_rdy_seen), 64'd0);
    check_eq("t3_inj_cnt",    64'(inj_cnt), 64'd1);
    check_eq("t3_pass_cnt",   64'(pass_cnt), 64'd3);
    inj_valid = 1'b0; inj_last = 1'b0;
    insert_en = 1'b1;

    // 4: inject arriving mid main packet waits for main tlast
    out_src_q.delete();
    fork
      send_pkt(0, 5, 5, 0);
      send_pkt(1, 6, 2, 3);
    join
    drain();
    check_eq("t4_nbeats", 64'(out_src_q.size()), 64'd7);
    if (out_src_q.size() == 7) begin
      check_eq("t4_src4", 64'(out_src_q[4]), 64'd0);
      check_eq("t4_src5", 64'(out_src_q[5]), 64'd1);
    end
    check_eq("t4_pass_cnt", 64'(pass_cnt), 64'd4);
    check_eq("t4_inj_cnt",  64'(inj_cnt), 64'd2);

    // 5: 100 packets under random backpressure; counters saturate at 15
    rnd_ready = 1'b1;
    fork
      begin
        for (int p = 0; p < 50; p++)
          send_pkt(0, 100 + p, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
      end
      begin
        for (int q = 0; q < 50; q++)
          send_pkt(1, 200 + q, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
      end
    join
    drain();
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    check_eq("t5_pass_sat", 64'(pass_cnt), 64'd15);
    check_eq("t5_inj_sat",  64'(inj_cnt), 64'd15);

    // 6: reset in the middle of a packet
    mon_en = 1'b0;
    pkt_valid = 1'b1; pkt_last = 1'b0; pkt_data = 64'h1234_5678_9ABC_DEF0; pkt_keep = 8'hFF;
    repeat (4) begin @(posedge clk); #1; end
    check_eq("t6_pre_m_valid", 64'(m_valid), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_pkt_tready", 64'(pkt_tready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    pkt_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_m_valid",  64'(m_valid), 64'd0);
    check_eq("t6_m_data",   m_data, 64'd0);
    check_eq("t6_pass_cnt", 64'(pass_cnt), 64'd0);
    check_eq("t6_inj_cnt",  64'(inj_cnt), 64'd0);
    check_eq("t6_state",    64'(dut.state_q), 64'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
